// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with NZCV status and a retired-instruction counter.
// Priority on every rising edge: rst, then freeze, then flush, then normal capture.
module exe_mem_reg #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             wb_en_in,
  input  logic             mem_r_en_in,
  input  logic             mem_w_en_in,
  input  logic             s_in,
  input  logic [31:0]      alu_res_in,
  input  logic [31:0]      val_rm_in,
  input  logic [3:0]       dest_in,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             valid_out,
  output logic             wb_en,
  output logic             mem_r_en,
  output logic             mem_w_en,
  output logic [31:0]      alu_res,
  output logic [31:0]      val_rm,
  output logic [3:0]       dest,
  output logic [3:0]       status,
  output logic [CNT_W-1:0] inst_count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      wb_en      <= 1'b0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      alu_res    <= 32'd0;
      val_rm     <= 32'd0;
      dest       <= 4'd0;
      status     <= 4'b0000;
      inst_count <= '0;
    end else if (!freeze) begin
      if (flush) begin
        // Bubble: kill the controls only; data and architectural state stay put.
        valid_out <= 1'b0;
        wb_en     <= 1'b0;
        mem_r_en  <= 1'b0;
        mem_w_en  <= 1'b0;
      end else begin
        valid_out <= valid_in;
        wb_en     <= wb_en_in & valid_in;
        mem_r_en  <= mem_r_en_in & valid_in;
        mem_w_en  <= mem_w_en_in & valid_in;
        alu_res   <= alu_res_in;
        val_rm    <= val_rm_in;
        dest      <= dest_in;
        if (valid_in) begin
          inst_count <= inst_count + CNT_W'(1);
          if (s_in) begin
            status <= {alu_res_in[31], (alu_res_in == 32'd0), alu_c, alu_v};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_exe_mem_reg.sv
// Bench for exe_mem_reg (CNT_W=4): directed vector table, counter wrap sequence,
// then randomized cycles checked against a rule-level reference model.
module tb_exe_mem_reg;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, freeze, flush, valid_in;
  logic             wb_en_in, mem_r_en_in, mem_w_en_in, s_in;
  logic [31:0]      alu_res_in, val_rm_in;
  logic [3:0]       dest_in;
  logic             alu_c, alu_v;
  logic             valid_out, wb_en, mem_r_en, mem_w_en;
  logic [31:0]      alu_res, val_rm;
  logic [3:0]       dest, status;
  logic [CNT_W-1:0] inst_count;

  int tests_run = 0;
  int tests_failed = 0;

  exe_mem_reg #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .s_in(s_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .alu_c(alu_c), .alu_v(alu_v),
    .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .val_rm(val_rm), .dest(dest), .status(status), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        r, fz, fl, vi, wb, mr, mw, s;
    logic [31:0] a, rm;
    logic [3:0]  d;
    logic        c, v;
    logic [3:0]  e_ctl;
    logic [31:0] e_alu, e_rm;
    logic [3:0]  e_dest, e_st;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: what the stage should hold after each edge.
  logic [3:0]       m_ctl;
  logic [31:0]      m_alu, m_rm;
  logic [3:0]       m_dest, m_st;
  logic [CNT_W-1:0] m_cnt;

  task automatic add_vec(input string n, input logic r, fz, fl, vi, wb, mr, mw, s,
                         input logic [31:0] a, rm, input logic [3:0] d, input logic c, v,
                         input logic [3:0] e_ctl, input logic [31:0] e_alu, e_rm,
                         input logic [3:0] e_dest, e_st, e_cnt);
    vec_t t;
    t.name = n; t.r = r; t.fz = fz; t.fl = fl; t.vi = vi; t.wb = wb; t.mr = mr; t.mw = mw;
    t.s = s; t.a = a; t.rm = rm; t.d = d; t.c = c; t.v = v;
    t.e_ctl = e_ctl; t.e_alu = e_alu; t.e_rm = e_rm; t.e_dest = e_dest; t.e_st = e_st;
    t.e_cnt = e_cnt;
    vecs.push_back(t);
  endtask

  // Drive one cycle's inputs, advance the model, then sample just after the edge.
  task automatic step(input logic r, fz, fl, vi, wb, mr, mw, s,
                      input logic [31:0] a, rm, input logic [3:0] d, input logic c, v);
    rst = r; freeze = fz; flush = fl; valid_in = vi;
    wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw; s_in = s;
    alu_res_in = a; val_rm_in = rm; dest_in = d; alu_c = c; alu_v = v;
    if (r) begin
      m_ctl = 0; m_alu = 0; m_rm = 0; m_dest = 0; m_st = 0; m_cnt = 0;
    end else if (fz) begin
      // everything held
    end else if (fl) begin
      m_ctl = 0;
    end else begin
      m_ctl  = vi ? {1'b1, wb, mr, mw} : 4'b0000;
      m_alu  = a;
      m_rm   = rm;
      m_dest = d;
      if (vi) begin
        m_cnt = CNT_W'((int'(m_cnt) + 1) % (1 << CNT_W));
        if (s) m_st = {a[31], a == 32'd0, c, v};
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [3:0] e_ctl, input logic [31:0] e_alu, e_rm,
                       input logic [3:0] e_dest, e_st, input logic [CNT_W-1:0] e_cnt);
    logic [79:0] act, exp;
    act = {valid_out, wb_en, mem_r_en, mem_w_en, alu_res, val_rm, dest, status, inst_count};
    exp = {e_ctl, e_alu, e_rm, e_dest, e_st, e_cnt};
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got ctl=%b alu=%h rm=%h dest=%h st=%b cnt=%0d, want ctl=%b alu=%h rm=%h dest=%h st=%b cnt=%0d",
               n, act[79:76], act[75:44], act[43:12], act[11:8], act[7:4], act[3:0],
               e_ctl, e_alu, e_rm, e_dest, e_st, e_cnt);
    end
  endtask

  initial begin
    //       name           r  fz fl vi wb mr mw s  alu_res_in    val_rm_in     d  c  v   ctl      alu           rm            dest  st       cnt
    add_vec("rst_cyc1",     1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        4'd0, 4'b0000, 4'd0);
    add_vec("rst_cyc2",     1, 0, 0, 1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h1,       7, 1, 1, 4'b0000, 32'h0,        32'h0,        4'd0, 4'b0000, 4'd0);
    add_vec("rst_release",  0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        4'd0, 4'b0000, 4'd0);
    add_vec("nzcv_neg",     0, 0, 0, 1, 1, 0, 0, 1, 32'h8000_0000, 32'h11,      5, 1, 1, 4'b1100, 32'h8000_0000, 32'h11,      4'd5, 4'b1011, 4'd1);
    add_vec("z_flag",       0, 0, 0, 1, 1, 0, 0, 1, 32'h0,        32'h22,       2, 0, 0, 4'b1100, 32'h0,        32'h22,       4'd2, 4'b0100, 4'd2);
    add_vec("no_s_hold_st", 0, 0, 0, 1, 1, 1, 0, 0, 32'h7,        32'h33,       3, 1, 1, 4'b1110, 32'h7,        32'h33,       4'd3, 4'b0100, 4'd3);
    add_vec("frz_fl_1",     0, 1, 1, 1, 1, 1, 1, 1, 32'hFFFF_0000, 32'h44,      8, 1, 0, 4'b1110, 32'h7,        32'h33,       4'd3, 4'b0100, 4'd3);
    add_vec("frz_fl_2",     0, 1, 1, 0, 0, 0, 1, 1, 32'h0,        32'h45,       9, 0, 1, 4'b1110, 32'h7,        32'h33,       4'd3, 4'b0100, 4'd3);
    add_vec("frz_fl_3",     0, 1, 1, 1, 0, 1, 0, 0, 32'h1234_5678, 32'h46,      10, 1, 1, 4'b1110, 32'h7,       32'h33,       4'd3, 4'b0100, 4'd3);
    add_vec("flush_only",   0, 0, 1, 1, 1, 1, 1, 1, 32'h1234,     32'h55,       11, 1, 1, 4'b0000, 32'h7,       32'h33,       4'd3, 4'b0100, 4'd3);
    add_vec("store",        0, 0, 0, 1, 0, 0, 1, 0, 32'h100,      32'hDEAD,     9, 0, 0, 4'b1001, 32'h100,      32'hDEAD,     4'd9, 4'b0100, 4'd4);
    add_vec("invalid_cap",  0, 0, 0, 0, 1, 1, 1, 1, 32'h8000_0001, 32'h66,      1, 1, 1, 4'b0000, 32'h8000_0001, 32'h66,      4'd1, 4'b0100, 4'd4);
    add_vec("freeze_hold",  0, 1, 0, 1, 1, 0, 0, 1, 32'h0,        32'h77,       2, 0, 0, 4'b0000, 32'h8000_0001, 32'h66,      4'd1, 4'b0100, 4'd4);
    add_vec("rst_in_frz",   1, 1, 1, 1, 1, 1, 1, 1, 32'hABCD,     32'h88,       4, 1, 1, 4'b0000, 32'h0,        32'h0,        4'd0, 4'b0000, 4'd0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].fz, vecs[i].fl, vecs[i].vi, vecs[i].wb, vecs[i].mr, vecs[i].mw,
           vecs[i].s, vecs[i].a, vecs[i].rm, vecs[i].d, vecs[i].c, vecs[i].v);
      check(vecs[i].name, vecs[i].e_ctl, vecs[i].e_alu, vecs[i].e_rm, vecs[i].e_dest,
            vecs[i].e_st, vecs[i].e_cnt);
    end

    // Counter wrap: 16 valid captures walk 1..15 then back to 0.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 1, 0, 0, 0, 32'(i + 1), 32'(i), 4'(i), 0, 0);
      check($sformatf("wrap_%0d", i), 4'b1100, 32'(i + 1), 32'(i), 4'(i), 4'b0000,
            4'((i + 1) % 16));
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 1, 1, 1, 1, 32'h0, 32'h5, 4'd6, 1, 1);
      check($sformatf("idle_%0d", i), 4'b0000, 32'h0, 32'h5, 4'd6, 4'b0000, 4'd0);
    end

    // Randomized cycles against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      step($urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
      check($sformatf("rand_%0d", i), m_ctl, m_alu, m_rm, m_dest, m_st, m_cnt);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port freeze  input  1  hold all registers (memory stall).
REQ-005 SHALL have port flush  input  1  insert bubble (branch taken).
REQ-006 SHALL have port valid_in  input  1  EXE stage holds a real instruction.
REQ-007 SHALL have ports wb_en_in, mem_r_en_in, mem_w_en_in, s_in  input  1 each  writeback, load, store and set-flags controls.
REQ-008 SHALL have port alu_res_in  input  32  ALU result.
REQ-009 SHALL have port val_rm_in  input  32  store data.
REQ-010 SHALL have port dest_in  input  4  destination register.
REQ-011 SHALL have ports alu_c, alu_v  input  1 each  ALU carry-out and overflow.
REQ-012 SHALL have ports valid_out, wb_en, mem_r_en, mem_w_en  output  1 each  registered controls.
REQ-013 SHALL have ports alu_res, val_rm  output  32 each  registered data.
REQ-014 SHALL have port dest  output  4  registered destination.
REQ-015 SHALL have port status  output  4  NZCV register; bit3=N, bit2=Z, bit1=C, bit0=V; status[1] feeds ALU carry.
REQ-016 SHALL have port inst_count  output  CNT_W  retired-instruction counter.

Function
REQ-017 SHALL update all state only on the rising edge of clk.
REQ-018 SHALL apply per-edge priority: rst > freeze > flush > normal capture.
REQ-019 Freeze: every register, including status and inst_count, SHALL hold its value; a flush asserted with freeze SHALL be ignored.
REQ-020 Flush without freeze: valid_out, wb_en, mem_r_en and mem_w_en SHALL become 0; alu_res, val_rm, dest SHALL hold; status and inst_count SHALL not change.
REQ-021 Normal capture: valid_out<=valid_in; each control output <= its input AND valid_in; alu_res, val_rm, dest SHALL capture their inputs unconditionally.
REQ-022 Latency SHALL be exactly one cycle from input to output; no combinational path SHALL exist from inputs to outputs.
REQ-023 Status SHALL update only on normal capture with valid_in=1 and s_in=1.
REQ-024 Status update values: N=alu_res_in[31]; Z=1 iff alu_res_in==0; C=alu_c; V=alu_v.
REQ-025 inst_count SHALL increment by 1 on each normal capture with valid_in=1; it SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-026 A store SHALL set mem_w_en=1 and wb_en=0 when the inputs so specify; the block SHALL not check control consistency.

Reset
REQ-027 With rst high at a clock edge, all outputs SHALL become 0: valid_out, controls, alu_res, val_rm, dest, status=4'b0000, inst_count.
REQ-028 Reset SHALL override freeze and flush on the same edge.
REQ-029 Reset asserted mid-stall SHALL clear the held instruction; no state SHALL survive.

Verification
REQ-030 Bench SHALL check: rst for 2 cycles, then release -> all outputs 0, status=0000, inst_count=0.
REQ-031 Bench SHALL check: valid_in=1, s_in=1, wb_en_in=1, alu_res_in=32'h8000_0000, alu_c=1, alu_v=1, dest_in=5 -> next cycle wb_en=1, dest=5, status=1011, inst_count=1.
REQ-032 Bench SHALL check: alu_res_in=0, s_in=1 -> Z=1; then s_in=0 with alu_res_in=7 -> status unchanged, alu_res=7.
REQ-033 Bench SHALL check: freeze=1 and flush=1 together for 3 cycles with changing inputs -> all outputs constant; freeze=0, flush=1 -> valid_out=0 and controls 0, alu_res held.
REQ-034 Bench SHALL check: CNT_W=4, 16 valid captures -> inst_count wraps 15 to 0; valid_in=0 captures -> no increment, controls 0.
REQ-035 Bench SHALL check: rst asserted while freeze=1 -> all outputs 0 next cycle.
